// File: rtl/wr_ctrl_if.sv
// Bundle of the start/done handshake, FIFO read side and Avalon-MM write port
// seen by the burst write master.
interface wr_ctrl_if #(
  parameter int USEDW_W = 9
);
  logic                wr_ctrl;
  logic [31:0]         control;
  logic [31:0]         pkt_begin;
  logic [31:0]         pkt_end;
  logic                wr_ctrl_rdy;
  logic [31:0]         fifo_out;
  logic [USEDW_W-1:0]  fifo_usedw;
  logic                fifo_empty;
  logic                rd_from_fifo;
  logic [31:0]         address;
  logic [31:0]         writedata;
  logic                write;
  logic [15:0]         burstcount;
  logic [3:0]          byteenable;
  logic                waitrequest;

  modport master (
    input  wr_ctrl, control, pkt_begin, pkt_end,
    input  fifo_out, fifo_usedw, fifo_empty, waitrequest,
    output wr_ctrl_rdy, rd_from_fifo,
    output address, writedata, write, burstcount, byteenable
  );

  modport slave (
    output wr_ctrl, control, pkt_begin, pkt_end,
    output fifo_out, fifo_usedw, fifo_empty, waitrequest,
    input  wr_ctrl_rdy, rd_from_fifo,
    input  address, writedata, write, burstcount, byteenable
  );
endinterface

// File: rtl/wr_ctrl.sv
// Avalon-MM burst write master: drains a show-ahead FIFO into [pkt_begin, pkt_end).
//   state     | meaning
//   IDLE      | waiting for a start pulse
//   WAIT_DATA | waiting until the FIFO holds the next whole burst
//   BURST     | write asserted, one beat per accepted cycle
//   DONE      | raise the one-cycle done pulse
module wr_ctrl #(
  parameter int MAX_BURST = 16,
  parameter int USEDW_W   = 9
) (
  input  logic      clk,
  input  logic      reset,
  wr_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DONE} state_t;

  state_t      state;
  logic [31:0] address_r;
  logic [31:0] control_r;
  logic [15:0] burstcount_r;
  logic [15:0] remaining;
  logic [15:0] beats;
  logic        write_r;
  logic        rdy_r;

  logic [31:0] span;
  logic [15:0] words;
  logic [15:0] bsize;
  logic        data_ready;
  logic        accept;
  logic        unused_bits;

  assign span       = bus.pkt_end - bus.pkt_begin;
  assign words      = span[17:2];
  assign bsize      = (remaining > 16'(MAX_BURST)) ? 16'(MAX_BURST) : remaining;
  assign data_ready = 32'(bus.fifo_usedw) >= 32'(bsize);
  assign accept     = write_r & ~bus.waitrequest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      address_r    <= '0;
      control_r    <= '0;
      burstcount_r <= '0;
      remaining    <= '0;
      beats        <= '0;
      write_r      <= 1'b0;
      rdy_r        <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_ctrl) begin
            control_r <= bus.control;
            address_r <= bus.pkt_begin;
            remaining <= words;
            state     <= (words == 16'd0) ? DONE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_ready) begin
            burstcount_r <= bsize;
            beats        <= bsize;
            write_r      <= 1'b1;
            state        <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beats <= beats - 16'd1;
            // burstcount_r still holds this burst's length on its last beat
            if (beats == 16'd1) begin
              write_r   <= 1'b0;
              address_r <= address_r + {14'd0, burstcount_r, 2'b00};
              remaining <= remaining - burstcount_r;
              state     <= (remaining == burstcount_r) ? DONE : WAIT_DATA;
            end
          end
        end
        DONE: begin
          rdy_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_from_fifo = accept;
  assign bus.wr_ctrl_rdy  = rdy_r;
  assign bus.address      = address_r;
  assign bus.writedata    = bus.fifo_out;
  assign bus.write        = write_r;
  assign bus.burstcount   = burstcount_r;
  assign bus.byteenable   = 4'hF;

  // control is latched but reserved; FIFO empty is implied by usedw
  assign unused_bits = ^{control_r, span[31:18], span[1:0], bus.fifo_empty};

endmodule

// File: tb/tb_wr_ctrl.sv
// Randomized bench for wr_ctrl: FIFO model, burst-plan reference model and a
// per-cycle compare process sampling on the falling edge.
module tb_wr_ctrl;
  localparam int MB = 16;
  localparam int UW = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wr_ctrl_if #(.USEDW_W(UW)) bus ();

  wr_ctrl #(.MAX_BURST(MB), .USEDW_W(UW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;

  // FIFO contents and reference model
  logic [31:0] fq[$];
  logic [31:0] exp_data[$];
  logic [31:0] ba_q[$];
  int          bc_q[$];
  logic [31:0] log_addr[$];
  int          log_cnt[$];

  int cyc = 0, wait_from = 0, beats_done = 0, pops = 0;
  int rdy_seen = 0, exp_rdy = 0, rdy_cyc = 0, last_beat_cyc = 0, start_cyc = 0;
  int stalls = 0;
  bit do_pop = 0, rand_wr = 0;

  bit p_write, p_wait, p_armed, p_last;
  int p_usedw;
  logic [31:0] p_addr, p_data;
  logic [15:0] p_bc;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fifo_drive();
    bus.fifo_usedw = UW'(fq.size());
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_out   = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    exp_data.push_back(w);
    fifo_drive();
  endtask

  // FIFO pops land just after the edge that accepted the beat
  always @(posedge clk) begin
    #1;
    if (do_pop) begin
      do_pop = 0;
      if (fq.size() != 0) void'(fq.pop_front());
      fifo_drive();
    end
  end

  always @(posedge clk) begin
    #2;
    bus.waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // compare process
  always @(negedge clk) begin
    bit armed, last;
    int cnt;
    cyc++;
    if (!reset) begin
      p_write = 0; p_wait = 0; p_armed = 0; p_last = 0; p_usedw = 0;
      do_pop = 0;
    end else begin
      last = 0;
      cnt = (bc_q.size() != 0) ? bc_q[0] : 0;
      chk(bus.byteenable == 4'hF, "byteenable", bus.byteenable, 4'hF);
      if (p_armed && cnt > 0 && p_usedw >= cnt)
        chk(bus.write == 1'b1, "write_rise_late", bus.write, 1);
      if (bus.write) begin
        if (cnt == 0) begin
          chk(1'b0, "unexpected_write", bus.address, 0);
        end else begin
          if (!p_write) begin
            chk(p_armed && p_usedw >= cnt, "write_rise_early", p_usedw, cnt);
            log_addr.push_back(bus.address);
            log_cnt.push_back(int'(bus.burstcount));
          end
          chk(!p_last, "burst_gap", 1, 0);
          chk(bus.address == ba_q[0], "address", bus.address, ba_q[0]);
          chk(int'(bus.burstcount) == cnt, "burstcount", bus.burstcount, cnt);
          if (p_write && p_wait) begin
            chk(bus.address == p_addr, "stall_address", bus.address, p_addr);
            chk(bus.burstcount == p_bc, "stall_burstcount", bus.burstcount, p_bc);
            chk(bus.writedata == p_data, "stall_writedata", bus.writedata, p_data);
          end
          if (!bus.waitrequest) begin
            chk(bus.rd_from_fifo == 1'b1, "pop_on_beat", bus.rd_from_fifo, 1);
            chk(!bus.fifo_empty, "pop_while_empty", bus.fifo_empty, 0);
            if (exp_data.size() != 0) begin
              chk(bus.writedata == exp_data[0], "writedata", bus.writedata, exp_data[0]);
              void'(exp_data.pop_front());
            end else begin
              chk(1'b0, "data_underrun", bus.writedata, 0);
            end
            pops++;
            do_pop = 1;
            beats_done++;
            if (beats_done == cnt) begin
              void'(ba_q.pop_front());
              void'(bc_q.pop_front());
              beats_done = 0;
              last = 1;
              last_beat_cyc = cyc;
              wait_from = cyc + 1;
            end
          end else begin
            stalls++;
            chk(bus.rd_from_fifo == 1'b0, "no_pop_stall", bus.rd_from_fifo, 0);
          end
        end
      end else begin
        chk(bus.rd_from_fifo == 1'b0, "no_pop_idle", bus.rd_from_fifo, 0);
      end
      if (bus.wr_ctrl_rdy) begin
        rdy_seen++;
        rdy_cyc = cyc;
        chk(bc_q.size() == 0, "rdy_early", bc_q.size(), 0);
      end
      armed = (bc_q.size() != 0) && !bus.write && (cyc >= wait_from);
      p_write = bus.write; p_wait = bus.waitrequest; p_usedw = int'(bus.fifo_usedw);
      p_addr = bus.address; p_bc = bus.burstcount; p_data = bus.writedata;
      p_last = last; p_armed = armed;
    end
  end

  task automatic start(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] a, span;
    int rem, n;
    @(posedge clk); #2;
    bus.pkt_begin = b;
    bus.pkt_end   = e;
    bus.control   = $urandom;
    bus.wr_ctrl   = 1'b1;
    start_cyc = cyc + 1;
    wait_from = cyc + 2;
    span = e - b;
    rem  = int'(span[17:2]);
    a    = b;
    while (rem > 0) begin
      n = (rem > MB) ? MB : rem;
      ba_q.push_back(a);
      bc_q.push_back(n);
      a   = a + 32'(n * 4);
      rem = rem - n;
    end
    exp_rdy++;
    @(posedge clk); #2;
    bus.wr_ctrl   = 1'b0;
    bus.pkt_begin = $urandom;
    bus.pkt_end   = $urandom;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && rdy_seen < exp_rdy; i++) @(posedge clk);
    chk(rdy_seen == exp_rdy, "done_timeout", rdy_seen, exp_rdy);
    repeat (3) @(posedge clk);
    chk(rdy_seen == exp_rdy, "rdy_once", rdy_seen, exp_rdy);
    chk(exp_data.size() == 0, "data_left", exp_data.size(), 0);
  endtask

  task automatic new_case();
    log_addr.delete();
    log_cnt.delete();
    pops = 0;
  endtask

  initial begin
    int n;
    logic [31:0] b;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pops_t2;
    logic [31:0] b;
    bus.wr_ctrl = 0; bus.control = 0; bus.pkt_begin = 0; bus.pkt_end = 0;
    bus.waitrequest = 0;
    fifo_drive();
    repeat (3) @(posedge clk);
    #1;
    chk(bus.address == 0, "reset_address", bus.address, 0);
    chk(bus.burstcount == 0, "reset_burstcount", bus.burstcount, 0);
    chk(bus.write == 0, "reset_write", bus.write, 0);
    chk(bus.wr_ctrl_rdy == 0, "reset_rdy", bus.wr_ctrl_rdy, 0);
    #1 reset = 1'b1;

    // T1 single short burst
    new_case();
    for (int i = 0; i < 4; i++) push($urandom);
    start(32'h1000, 32'h1010);
    wait_done(200);
    chk(log_addr.size() == 1, "t1_bursts", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk(log_addr[0] == 32'h1000, "t1_addr", log_addr[0], 32'h1000);
      chk(log_cnt[0] == 4, "t1_count", log_cnt[0], 4);
    end
    chk(pops == 4, "t1_pops", pops, 4);
    chk(rdy_cyc > last_beat_cyc && rdy_cyc - last_beat_cyc <= 2, "t1_rdy_after_last",
        rdy_cyc - last_beat_cyc, 2);

    // T2 multi-burst, then T3 same traffic with random stalls
    for (int pass = 0; pass < 2; pass++) begin
      new_case();
      rand_wr = (pass == 1);
      stalls = 0;
      for (int i = 0; i < 37; i++) push($urandom);
      start(32'h0, 32'h94);
      wait_done(2000);
      rand_wr = 0;
      chk(log_addr.size() == 3, "t2_bursts", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
        chk(log_addr[0] == 32'h00 && log_cnt[0] == 16, "t2_burst0", log_addr[0], 32'h00);
        chk(log_addr[1] == 32'h40 && log_cnt[1] == 16, "t2_burst1", log_addr[1], 32'h40);
        chk(log_addr[2] == 32'h80 && log_cnt[2] == 5, "t2_burst2", log_addr[2], 32'h80);
      end
      chk(pops == 37, "t2_pops", pops, 37);
      if (pass == 1) chk(stalls > 0, "t3_stalls_seen", stalls, 1);
    end

    // T4 starved FIFO fed one word every 3 cycles
    new_case();
    fork
      for (int i = 0; i < 20; i++) begin
        repeat (3) @(posedge clk);
        #2 push($urandom);
      end
    join_none
    start(32'h4000, 32'h4050);
    wait_done(2000);
    chk(log_cnt.size() == 2, "t4_bursts", log_cnt.size(), 2);
    if (log_cnt.size() == 2) begin
      chk(log_cnt[0] == 16 && log_addr[0] == 32'h4000, "t4_burst0", log_cnt[0], 16);
      chk(log_cnt[1] == 4 && log_addr[1] == 32'h4040, "t4_burst1", log_cnt[1], 4);
    end

    // T5 zero length, then a start pulse during a burst
    new_case();
    start(32'h5000, 32'h5000);
    wait_done(100);
    chk(rdy_cyc - start_cyc == 2, "t5_zero_rdy_delay", rdy_cyc - start_cyc, 2);
    chk(log_addr.size() == 0, "t5_zero_no_write", log_addr.size(), 0);
    new_case();
    for (int i = 0; i < 8; i++) push($urandom);
    start(32'h6000, 32'h6020);
    for (int i = 0; i < 100 && !bus.write; i++) @(posedge clk);
    @(posedge clk); #2;
    bus.pkt_begin = 32'h7000; bus.pkt_end = 32'h7040; bus.wr_ctrl = 1'b1;
    @(posedge clk); #2;
    bus.wr_ctrl = 1'b0;
    wait_done(200);
    repeat (10) @(posedge clk);
    chk(rdy_seen == exp_rdy, "t5_ignored_start", rdy_seen, exp_rdy);
    chk(log_addr.size() == 1, "t5_one_burst", log_addr.size(), 1);

    // T6 reset on beat 7 of 16
    new_case();
    for (int i = 0; i < 32; i++) push($urandom);
    start(32'h8000, 32'h8080);
    for (int i = 0; i < 200 && beats_done != 7; i++) begin
      @(negedge clk); #1;
    end
    chk(beats_done == 7, "t6_reach_beat7", beats_done, 7);
    reset = 1'b0;
    #1;
    chk(bus.write == 0, "t6_async_write", bus.write, 0);
    chk(bus.wr_ctrl_rdy == 0, "t6_async_rdy", bus.wr_ctrl_rdy, 0);
    ba_q.delete(); bc_q.delete(); exp_data.delete(); fq.delete();
    beats_done = 0; do_pop = 0; exp_rdy = rdy_seen;
    fifo_drive();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    new_case();
    for (int i = 0; i < 8; i++) push($urandom);
    start(32'h9000, 32'h9020);
    wait_done(200);
    chk(log_addr.size() == 1 && log_addr[0] == 32'h9000, "t6_restart_addr",
        (log_addr.size() != 0) ? log_addr[0] : 0, 32'h9000);
    chk(pops == 8, "t6_restart_pops", pops, 8);

    // address wrap at the top of the 32-bit space
    new_case();
    for (int i = 0; i < 4; i++) push($urandom);
    start(32'hFFFF_FFF8, 32'h0000_0008);
    wait_done(200);
    chk(log_addr.size() == 1 && log_cnt[0] == 4, "wrap_burst", log_cnt.size(), 1);

    // random transfers with random stalls
    for (int k = 0; k < 5; k++) begin
      new_case();
      n = $urandom_range(1, 45);
      b = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
      for (int i = 0; i < n; i++) push($urandom);
      rand_wr = 1;
      start(b, b + 32'(n * 4));
      wait_done(3000);
      rand_wr = 0;
      chk(pops == n, "rand_pops", pops, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
